// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU operator codes,
// move-port encoding, issue FSM states and the divide-by-zero result value.
package alu_issue_ctrl_pkg;

   // Operator codes understood by the ALU datapath
   typedef enum logic [3:0] {
      ALU_NOP = 4'd0,
      ALU_ADD = 4'd1,
      ALU_SUB = 4'd2,
      ALU_MUL = 4'd3,
      ALU_DIV = 4'd4,
      ALU_MOD = 4'd5,
      ALU_AND = 4'd6,
      ALU_OR  = 4'd7,
      ALU_XOR = 4'd8,
      ALU_SL  = 4'd9,
      ALU_SR  = 4'd10
   } alu_operator_e;

   // Which unit port a bus move targets
   typedef enum logic {
      ALU_PORT_A    = 1'b0,
      ALU_PORT_TRIG = 1'b1
   } alu_port_e;

   // Issue sequence: select the ALU, capture its registered output, hold it
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESULT  = 2'd3
   } alu_issue_state_e;

   // Wide enough for any supported datapath; users take the low DATA_W bits
   localparam logic [63:0] DIVZERO_RESULT = '1;

   // True for operators whose second operand is a divisor
   function automatic logic is_div_op(input alu_operator_e op);
      return (op == ALU_DIV) || (op == ALU_MOD);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: turns operand/trigger bus moves into a one-cycle ALU
// select, captures the registered ALU output and holds it in a one-deep result
// buffer with a valid/ready handshake.
// Optional build macro: ALU_DIVZERO_TRAP_EN adds divz_o and suppresses the ALU
// select for DIV/MOD by zero, returning all-ones instead.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                wr_valid_i,
   output logic                wr_ready_o,
   input  logic                wr_port_i,
   input  alu_operator_e       wr_oper_i,
   input  logic [DATA_W-1:0]   wr_data_i,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [DATA_W-1:0]   res_data_o,
   output logic                busy_o,
`ifdef ALU_DIVZERO_TRAP_EN
   output logic                divz_o,
`endif
   output logic                alu_sel_o,
   output alu_operator_e       alu_oper_o,
   output logic [DATA_W-1:0]   alu_a_o,
   output logic [DATA_W-1:0]   alu_b_o,
   input  logic [DATA_W-1:0]   alu_data_i
);

   alu_issue_state_e state_q, state_d;
   logic [DATA_W-1:0] reg_a, reg_b, res_data_q;
   alu_operator_e     reg_oper;
   logic              trig_ok, trig_accept, a_accept;

   // A trigger may start a new operation from IDLE, or from RESULT in the same
   // cycle the held result is consumed, giving back-to-back issue.
   assign trig_ok     = (state_q == IDLE) || ((state_q == RESULT) && res_ready_i);
   assign trig_accept = wr_valid_i && (wr_port_i == ALU_PORT_TRIG) && trig_ok;
   assign a_accept    = wr_valid_i && (wr_port_i == ALU_PORT_A) && (state_q != ISSUE);

   assign alu_a_o    = reg_a;
   assign alu_b_o    = reg_b;
   assign alu_oper_o = reg_oper;
   assign res_data_o = res_data_q;

`ifdef ALU_DIVZERO_TRAP_EN
   logic divz_q;

   // Remember whether the issued operation divides by zero; cleared on consume
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         divz_q <= 1'b0;
      end else if (trig_accept) begin
         divz_q <= is_div_op(wr_oper_i) && (wr_data_i == '0);
      end else if ((state_q == RESULT) && res_ready_i) begin
         divz_q <= 1'b0;
      end
   end

   assign divz_o = divz_q && (state_q == RESULT);
`endif

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand, operator and result registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         reg_a      <= '0;
         reg_b      <= '0;
         reg_oper   <= ALU_NOP;
         res_data_q <= '0;
      end else begin
         if (a_accept) begin
            reg_a <= wr_data_i;
         end
         if (trig_accept) begin
            reg_b    <= wr_data_i;
            reg_oper <= wr_oper_i;
         end
         if (state_q == CAPTURE) begin
`ifdef ALU_DIVZERO_TRAP_EN
            res_data_q <= divz_q ? DIVZERO_RESULT[DATA_W-1:0] : alu_data_i;
`else
            res_data_q <= alu_data_i;
`endif
         end
      end
   end

   // Next-state logic: fixed ISSUE -> CAPTURE -> RESULT walk, leave RESULT on consume
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (trig_accept) state_d = ISSUE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = RESULT;
         RESULT:  if (res_ready_i) state_d = trig_accept ? ISSUE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the current state
   always_comb begin
      wr_ready_o  = (wr_port_i == ALU_PORT_TRIG) ? trig_ok : (state_q != ISSUE);
      busy_o      = (state_q == ISSUE) || (state_q == CAPTURE);
      res_valid_o = (state_q == RESULT);
`ifdef ALU_DIVZERO_TRAP_EN
      alu_sel_o   = (state_q == ISSUE) && !divz_q;
`else
      alu_sel_o   = (state_q == ISSUE);
`endif
   end

endmodule
